game_timer: RTL and testbench
=============================

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, clk cycles per game second; legal range >= 2.
REQ-002 Parameter GAME_SECONDS, default 30, round length in seconds; legal range 1..99, elaboration error outside it.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high global reset.
REQ-005 sys_reset  input  1  synchronous, active-high round reset from game FSM; level, may be held many cycles.
REQ-006 game_active  input  1  synchronous run enable from game FSM; level.
REQ-007 game_time_up  output  1  high while round has expired; synchronous to clk, glitch-free (decoded from registered state only).
REQ-008 sec_tens  output  4  remaining seconds, BCD tens digit, 0..9.
REQ-009 sec_ones  output  4  remaining seconds, BCD ones digit, 0..9.
REQ-010 sec_tick  output  1  one-cycle pulse in the cycle after each decrement of remaining seconds.
REQ-011 warn  output  1  high when state is RUN and remaining seconds <= 5.
REQ-012 timer_state_debug  output  2  current state encoding: READY=00, RUN=01, HOLD=10, EXPIRED=11.

Function
REQ-013 Four-state Moore FSM: READY, RUN, HOLD, EXPIRED; game_time_up high only in EXPIRED.
REQ-014 Priority per edge: reset (async) > sys_reset > game_active/tick logic.
REQ-015 sys_reset=1 in any state: next state READY, digits reload to GAME_SECONDS (tens=GAME_SECONDS/10, ones=GAME_SECONDS%10), prescaler cleared to 0, no sec_tick.
REQ-016 READY: game_active=1 and sys_reset=0 -> RUN, prescaler cleared; otherwise stay READY.
REQ-017 RUN: prescaler counts 0..CLK_HZ-1 each cycle, wraps to 0; terminal count (CLK_HZ-1) = one-second tick.
REQ-018 RUN, tick: remaining seconds decrement by one in BCD (ones=0 -> ones=9, tens-1; else ones-1).
REQ-019 RUN, tick with remaining = 01: digits become 00 and state becomes EXPIRED at the same edge; game_time_up high in the first cycle digits read 00.
REQ-020 RUN, game_active=0: -> HOLD; prescaler and digits frozen at current values, no decrement that cycle even if prescaler at terminal.
REQ-021 HOLD: game_active=1 -> RUN, prescaler resumes from frozen value (not cleared); otherwise stay HOLD.
REQ-022 EXPIRED: digits held at 00, prescaler held; ignores game_active; exits only via sys_reset or reset.
REQ-023 sec_tick registered: asserted exactly one cycle, the cycle after each decrement edge, including the 01->00 edge; never asserted in READY except that trailing cycle cannot occur there.
REQ-024 Digits never underflow: no decrement in any state other than RUN, and never below 00.
REQ-025 Full round length in RUN without pauses: exactly GAME_SECONDS*CLK_HZ cycles from entering RUN to first cycle of EXPIRED.
REQ-026 Prescaler width = ceil(log2(CLK_HZ)) bits; no other arithmetic wider than 4-bit BCD digits.

Reset
REQ-027 reset=1: state READY, digits = GAME_SECONDS in BCD, prescaler 0, game_time_up=0, sec_tick=0, warn=0, timer_state_debug=00, immediately and independent of clk.
REQ-028 reset asserted mid-RUN or mid-EXPIRED: same values as REQ-027; on release, READY until game_active=1.

Verification (CLK_HZ=4, GAME_SECONDS=12)
REQ-029 reset pulse, then game_active=1 held -> digits 1,2 at start; 1,1 after 4 cycles; 0,9 after 12 cycles with sec_tick pulse after each decrement; game_time_up rises exactly 48 cycles after entering RUN, digits 0,0.
REQ-030 Run 6 cycles, drop game_active 10 cycles, reassert -> digits stay 1,1 during HOLD, state 10; next decrement 2 cycles after reassert; total expiry 48 RUN cycles.
REQ-031 EXPIRED, toggle game_active -> game_time_up stays 1, digits 0,0; then sys_reset 1 cycle -> READY, digits 1,2, game_time_up 0 next cycle.
REQ-032 sys_reset and game_active both 1 in RUN at prescaler terminal -> READY, digits 1,2, no sec_tick; after sys_reset falls, RUN next edge.
REQ-033 warn: RUN reaching 0,5 -> warn=1; through 0,1; warn=0 in EXPIRED and in HOLD.
REQ-034 Async reset asserted between clock edges mid-RUN at digits 0,7 -> outputs reach REQ-027 values before next clk edge.

Source files
------------

// File: rtl/game_timer_if.sv
// Control and status signals between the game FSM and the round timer.
// All signals are plain levels or one-cycle pulses; there is no valid/ready handshake.
interface game_timer_if;
    logic       sys_reset;
    logic       game_active;
    logic       game_time_up;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_tick;
    logic       warn;
    logic [1:0] timer_state_debug;

    modport master (
        output sys_reset, game_active,
        input  game_time_up, sec_tens, sec_ones, sec_tick, warn, timer_state_debug
    );

    modport slave (
        input  sys_reset, game_active,
        output game_time_up, sec_tens, sec_ones, sec_tick, warn, timer_state_debug
    );
endinterface

// File: rtl/game_timer.sv
// Round countdown timer: BCD seconds counting down from GAME_SECONDS while the game
// is active, with pause (HOLD), expiry flag, per-second tick and low-time warning.
module game_timer #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 30
) (
    input  logic        clk,
    input  logic        reset,
    game_timer_if.slave bus
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TERM  = PW'(CLK_HZ - 1);
    localparam logic [3:0]    RELOAD_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]    RELOAD_ONES = 4'(GAME_SECONDS % 10);

    if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_seconds
        $error("game_timer: GAME_SECONDS must be in 1..99");
    end
    if (CLK_HZ < 2) begin : g_bad_clk
        $error("game_timer: CLK_HZ must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_READY   = 2'b00,
        ST_RUN     = 2'b01,
        ST_HOLD    = 2'b10,
        ST_EXPIRED = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_READY;
            presc_q <= '0;
            tens_q  <= RELOAD_TENS;
            ones_q  <= RELOAD_ONES;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        tick_d  = 1'b0;
        if (bus.sys_reset) begin
            state_d = ST_READY;
            presc_d = '0;
            tens_d  = RELOAD_TENS;
            ones_d  = RELOAD_ONES;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (bus.game_active) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    // Dropping game_active wins over a terminal count: freeze everything.
                    if (!bus.game_active) begin
                        state_d = ST_HOLD;
                    end else if (presc_q == PRESC_TERM) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            state_d = ST_EXPIRED;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.game_active) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
            endcase
        end
    end

    assign bus.game_time_up      = (state_q == ST_EXPIRED);
    assign bus.sec_tens          = tens_q;
    assign bus.sec_ones          = ones_q;
    assign bus.sec_tick          = tick_q;
    assign bus.warn              = (state_q == ST_RUN) && (tens_q == 4'd0) && (ones_q <= 4'd5);
    assign bus.timer_state_debug = state_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer with CLK_HZ=4, GAME_SECONDS=12: directed table, corner sequences,
// and random control stimulus checked against an elapsed-cycle reference model.
module tb_game_timer;

    localparam int C     = 4;
    localparam int G     = 12;
    localparam int TOTAL = C * G;

    localparam int M_READY   = 0;
    localparam int M_RUN     = 1;
    localparam int M_HOLD    = 2;
    localparam int M_EXPIRED = 3;

    logic clk = 1'b0;
    logic reset;

    game_timer_if bus ();

    game_timer #(.CLK_HZ(C), .GAME_SECONDS(G)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: total RUN cycles consumed this round determine everything.
    int m_mode;
    int m_run;
    int m_tick;

    typedef struct {
        logic       sr;
        logic       ga;
        logic [1:0] st;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       tick;
        logic       up;
        logic       warn;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [12:0] dut_pack();
        return {bus.timer_state_debug, bus.sec_tens, bus.sec_ones,
                bus.sec_tick, bus.game_time_up, bus.warn};
    endfunction

    function automatic void model_reset();
        m_mode = M_READY;
        m_run  = 0;
        m_tick = 0;
    endfunction

    function automatic void model_edge(input logic sr, input logic ga);
        m_tick = 0;
        if (sr) begin
            m_mode = M_READY;
            m_run  = 0;
        end else if (m_mode == M_READY) begin
            if (ga) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!ga) begin
                m_mode = M_HOLD;
            end else begin
                m_run = m_run + 1;
                if (m_run % C == 0) m_tick = 1;
                if (m_run == TOTAL) m_mode = M_EXPIRED;
            end
        end else if (m_mode == M_HOLD) begin
            if (ga) m_mode = M_RUN;
        end
    endfunction

    function automatic logic [12:0] model_pack();
        int rem;
        logic [1:0] st;
        logic [3:0] t, o;
        logic w;
        rem = G - m_run / C;
        st  = 2'(m_mode);
        t   = 4'(rem / 10);
        o   = 4'(rem % 10);
        w   = (m_mode == M_RUN) && (rem <= 5);
        return {st, t, o, 1'(m_tick), 1'(m_mode == M_EXPIRED), w};
    endfunction

    task automatic compare(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%b t=%0d o=%0d tick=%b up=%b warn=%b, exp st=%b t=%0d o=%0d tick=%b up=%b warn=%b",
                     name, got[12:11], got[10:7], got[6:3], got[2], got[1], got[0],
                     exp[12:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, exp %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic sr, input logic ga, input string name);
        bus.sys_reset   = sr;
        bus.game_active = ga;
        @(posedge clk);
        model_edge(sr, ga);
        @(negedge clk);
        compare(name, dut_pack(), model_pack());
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.sys_reset   = 1'b0;
        bus.game_active = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare("reset_held", dut_pack(), model_pack());
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        bus.sys_reset   = 1'b0;
        bus.game_active = 1'b0;
        model_reset();

        //             sr    ga    st     tens  ones  tick  up    warn
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 2'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 2'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 2'd2, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};

        // Directed table
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.sys_reset   = tbl[i].sr;
            bus.game_active = tbl[i].ga;
            @(posedge clk);
            @(negedge clk);
            compare($sformatf("table[%0d]", i), dut_pack(),
                    {tbl[i].st, tbl[i].tens, tbl[i].ones, tbl[i].tick, tbl[i].up, tbl[i].warn});
        end

        // Full uninterrupted round, then EXPIRED ignores game_active until sys_reset
        do_reset();
        step(1'b0, 1'b1, "round_enter");
        n = 0;
        while (!bus.game_time_up && n < 200) begin
            step(1'b0, 1'b1, "round_run");
            n++;
        end
        check_int("round_length", n, TOTAL);
        step(1'b0, 1'b0, "expired_ga0");
        step(1'b0, 1'b1, "expired_ga1");
        step(1'b0, 1'b0, "expired_ga0b");
        check_int("expired_up", int'(bus.game_time_up), 1);
        step(1'b1, 1'b0, "expired_sysreset");
        step(1'b0, 1'b0, "after_sysreset");

        // sys_reset wins over a terminal-count tick in RUN
        do_reset();
        step(1'b0, 1'b1, "term_enter");
        for (int i = 0; i < C - 1; i++) step(1'b0, 1'b1, "term_run");
        step(1'b1, 1'b1, "term_sysreset");
        step(1'b0, 1'b1, "term_rerun");
        check_int("term_rerun_state", int'(bus.timer_state_debug), 1);

        // Pause exactly at terminal count: no decrement on the HOLD edge
        do_reset();
        step(1'b0, 1'b1, "holdterm_enter");
        for (int i = 0; i < C - 1; i++) step(1'b0, 1'b1, "holdterm_run");
        step(1'b0, 1'b0, "holdterm_hold");
        step(1'b0, 1'b1, "holdterm_resume");
        step(1'b0, 1'b1, "holdterm_tick");

        // Asynchronous reset between edges while showing 0,7
        do_reset();
        step(1'b0, 1'b1, "async_enter");
        n = 0;
        while (!(bus.sec_tens == 4'd0 && bus.sec_ones == 4'd7) && n < 100) begin
            step(1'b0, 1'b1, "async_run");
            n++;
        end
        if (n >= 100) begin
            n_err++;
            $display("FAIL async_reach07: timeout after %0d cycles", n);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare("async_reset", dut_pack(), model_pack());
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, "async_release_ready");
        step(1'b0, 1'b1, "async_release_run");

        // Randomized control stimulus against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic sr, ga;
            sr = ($urandom_range(0, 89) == 0);
            ga = ($urandom_range(0, 9) != 0);
            step(sr, ga, $sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
